// File: rtl/deff_ddr_capture.sv
// deff_ddr_capture: receive side of a dual-edge data path.
// Each rising-edge beat is paired with the following falling-edge beat.
// Completed pairs go through a small first-word-fall-through FIFO that
// drains on a posedge valid/ready stream.
module deff_ddr_capture #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [W-1:0]               ddr_data,
  input  logic                       ddr_valid,
  input  logic                       capture_en,
  output logic [2*W-1:0]             m_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow,
  input  logic                       clr_ovf,
  output logic [CNT_W-1:0]           pair_cnt
);

  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     rise_q, rise_d;
  logic [W-1:0]     fall_q, fall_d;
  logic             pend_q, pend_d;
  logic [2*W-1:0]   mem_q [DEPTH];
  logic [2*W-1:0]   mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic push, pop, full, accept, drop;

  // Capture: rising beat and pending flag on posedge; falling beat taken every negedge.
  always_comb begin
    rise_d = rise_q;
    pend_d = capture_en && ddr_valid;
    fall_d = ddr_data;
    if (capture_en && ddr_valid) begin
      rise_d = ddr_data;
    end
  end

  // FIFO control: a pending pair pushes on the next posedge; a full FIFO
  // still accepts when the head is popped in the same cycle.
  always_comb begin
    push     = pend_q;
    pop      = (level_q != '0) && m_ready;
    full     = (level_q == LVL_W'(DEPTH));
    accept   = push && (!full || pop);
    drop     = push && full && !pop;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (accept) begin
      mem_d[wr_ptr_q] = {fall_q, rise_q};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({accept, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    // A drop in the same cycle as a clear leaves the flag set.
    ovf_d = drop ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);
    cnt_d = accept ? cnt_q + 1'b1 : cnt_q;
  end

  // Posedge state: rising beat, pending flag, FIFO, overflow and counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_q   <= '0;
      pend_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rise_q   <= rise_d;
      pend_q   <= pend_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
      mem_q    <= mem_d;
    end
  end

  // Negedge state: falling beat, cleared by the same async reset.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fall_q <= '0;
    end else begin
      fall_q <= fall_d;
    end
  end

  assign m_data   = mem_q[rd_ptr_q];
  assign m_valid  = (level_q != '0);
  assign level    = level_q;
  assign overflow = ovf_q;
  assign pair_cnt = cnt_q;

endmodule

// File: tb/tb_deff_ddr_capture.sv
// Bench for deff_ddr_capture: a hand-derived vector table, hand sequences for
// the enable/reset corners, and a queue scoreboard checking every cycle.
module tb_deff_ddr_capture;

  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic [W-1:0]     ddr_data;
  logic             ddr_valid;
  logic             capture_en;
  logic [2*W-1:0]   m_data;
  logic             m_valid;
  logic             m_ready;
  logic [2:0]       level;
  logic             overflow;
  logic             clr_ovf;
  logic [CNT_W-1:0] pair_cnt;

  deff_ddr_capture #(.W(W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ddr_data   (ddr_data),
    .ddr_valid  (ddr_valid),
    .capture_en (capture_en),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .level      (level),
    .overflow   (overflow),
    .clr_ovf    (clr_ovf),
    .pair_cnt   (pair_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [15:0]      sb_q[$];
  logic             m_pend;
  logic [7:0]       m_rise;
  logic [7:0]       m_fall;
  logic             m_ovf;
  logic [CNT_W-1:0] m_cnt;

  typedef struct {
    logic [7:0]  rise;
    logic [7:0]  fall;
    logic        v;
    logic        e;
    logic        r;
    logic        c;
    logic        ev;
    logic [15:0] ed;
    logic [2:0]  el;
    logic        eo;
    logic [3:0]  ec;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    sb_q.delete();
    m_pend = 1'b0;
    m_rise = 8'h00;
    m_fall = 8'h00;
    m_ovf  = 1'b0;
    m_cnt  = '0;
  endtask

  task automatic check_model();
    chk("sb_valid", 32'(m_valid), 32'(sb_q.size() != 0));
    chk("sb_level", 32'(level), 32'(sb_q.size()));
    chk("sb_ovf", 32'(overflow), 32'(m_ovf));
    chk("sb_cnt", 32'(pair_cnt), 32'(m_cnt));
    if (sb_q.size() != 0) chk("sb_head", 32'(m_data), 32'(sb_q[0]));
  endtask

  // One clock cycle: rise beat before posedge, fall beat before negedge.
  // Entered and left just after a negedge.
  task automatic cyc(input logic [7:0] rise, input logic [7:0] fall,
                     input logic v, input logic e, input logic r, input logic c);
    bit full_b, pop_b, drop_b;
    ddr_data   = rise;
    ddr_valid  = v;
    capture_en = e;
    m_ready    = r;
    clr_ovf    = c;
    if (r && sb_q.size() != 0) chk("pop_data", 32'(m_data), 32'(sb_q[0]));
    @(posedge clk);
    full_b = (sb_q.size() == DEPTH);
    pop_b  = r && (sb_q.size() != 0);
    drop_b = 1'b0;
    if (pop_b) void'(sb_q.pop_front());
    if (m_pend) begin
      if (full_b && !pop_b) begin
        drop_b = 1'b1;
        m_ovf  = 1'b1;
      end else begin
        sb_q.push_back({m_fall, m_rise});
        m_cnt = m_cnt + 1'b1;
      end
    end
    if (c && !drop_b) m_ovf = 1'b0;
    m_pend = v && e;
    if (v && e) m_rise = rise;
    #1;
    ddr_data = fall;
    @(negedge clk);
    m_fall = fall;
    #1;
    check_model();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(m_valid), 32'd0);
    chk({tag, "_data"}, 32'(m_data), 32'd0);
    chk({tag, "_level"}, 32'(level), 32'd0);
    chk({tag, "_ovf"}, 32'(overflow), 32'd0);
    chk({tag, "_cnt"}, 32'(pair_cnt), 32'd0);
  endtask

  initial begin
    tbl[0]  = '{8'h3C, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 4'd0};
    tbl[1]  = '{8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'hA53C, 3'd1, 1'b0, 4'd1};
    tbl[2]  = '{8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 4'd1};
    tbl[3]  = '{8'h11, 8'h81, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 4'd1};
    tbl[4]  = '{8'h22, 8'h82, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h8111, 3'd1, 1'b0, 4'd2};
    tbl[5]  = '{8'h33, 8'h83, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h8111, 3'd2, 1'b0, 4'd3};
    tbl[6]  = '{8'h44, 8'h84, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h8111, 3'd3, 1'b0, 4'd4};
    tbl[7]  = '{8'h55, 8'h85, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h8111, 3'd4, 1'b0, 4'd5};
    tbl[8]  = '{8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h8111, 3'd4, 1'b1, 4'd5};
    tbl[9]  = '{8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h8111, 3'd4, 1'b0, 4'd5};
    tbl[10] = '{8'h66, 8'h86, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h8111, 3'd4, 1'b0, 4'd5};
    tbl[11] = '{8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h8222, 3'd4, 1'b0, 4'd6};
    tbl[12] = '{8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h8333, 3'd3, 1'b0, 4'd6};
    tbl[13] = '{8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h8444, 3'd2, 1'b0, 4'd6};
    tbl[14] = '{8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h8666, 3'd1, 1'b0, 4'd6};
    tbl[15] = '{8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 4'd6};

    rst_n      = 1'b0;
    ddr_data   = '0;
    ddr_valid  = 1'b0;
    capture_en = 1'b0;
    m_ready    = 1'b0;
    clr_ovf    = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    // Single pair, burst to full, overflow with clear, full push+pop, drain
    for (int i = 0; i < 16; i++) begin
      cyc(tbl[i].rise, tbl[i].fall, tbl[i].v, tbl[i].e, tbl[i].r, tbl[i].c);
      chk($sformatf("tbl%0d_valid", i), 32'(m_valid), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_level", i), 32'(level), 32'(tbl[i].el));
      chk($sformatf("tbl%0d_ovf", i), 32'(overflow), 32'(tbl[i].eo));
      chk($sformatf("tbl%0d_cnt", i), 32'(pair_cnt), 32'(tbl[i].ec));
      if (tbl[i].ev) chk($sformatf("tbl%0d_data", i), 32'(m_data), 32'(tbl[i].ed));
    end

    // capture_en low blocks valid beats
    for (int i = 0; i < 10; i++) cyc(8'(i), 8'(i + 16), 1'b1, 1'b0, 1'b0, 1'b0);
    chk("en_off_valid", 32'(m_valid), 32'd0);
    chk("en_off_cnt", 32'(pair_cnt), 32'd6);

    // capture_en dropping right after a valid beat: pair still completes
    cyc(8'h77, 8'h87, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(8'h78, 8'h88, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("en_drop_data", 32'(m_data), 32'h8777);
    chk("en_drop_level", 32'(level), 32'd1);
    chk("en_drop_cnt", 32'(pair_cnt), 32'd7);
    cyc(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset asserted just after a negedge in the middle of a burst
    cyc(8'hA1, 8'hB1, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(8'hA2, 8'hB2, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(8'hA3, 8'hB3, 1'b1, 1'b1, 1'b0, 1'b0);
    rst_n     = 1'b0;
    ddr_valid = 1'b0;
    #1;
    chk_zero("midrst");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    cyc(8'hC1, 8'hD1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("post_rst_valid0", 32'(m_valid), 32'd0);
    cyc(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("post_rst_data", 32'(m_data), 32'hD1C1);
    chk("post_rst_cnt", 32'(pair_cnt), 32'd1);
    chk("post_rst_level", 32'(level), 32'd1);

    // Random traffic against the scoreboard; counter wraps along the way
    for (int i = 0; i < 120; i++) begin
      cyc(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 7) == 0));
    end
    for (int i = 0; i < 6; i++) cyc(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("final_empty", 32'(m_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
